// File: rtl/cct_update_scheduler.sv
// Sequencer in front of the CCT-to-XYZ converter: launches a conversion on a
// hysteresis-qualified ALS change or a forced request, then tracks it to commit or timeout.
module cct_update_scheduler #(
    parameter logic [15:0] HYST         = 16'd50,
    parameter logic [23:0] MIN_INTERVAL = 24'd1000,
    parameter logic [7:0]  TIMEOUT      = 8'd16,
    parameter logic [15:0] DEFAULT_CCT  = 16'd6500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] als_cct,
    input  logic        als_valid,
    input  logic        force_update,
    input  logic        err_clr,
    output logic [15:0] conv_cct,
    output logic        conv_start,
    input  logic        conv_done,
    output logic        busy,
    output logic        update_done,
    output logic [15:0] last_cct,
    output logic [15:0] update_count,
    output logic        timeout_err
);
    // Handshake: conv_start is a one-cycle launch with conv_cct held stable until the
    // transaction ends; conv_done is honoured only while waiting for the result.
    typedef enum logic [2:0] {
        IDLE,
        WAIT_SAMPLE,
        LAUNCH,
        WAIT_DONE,
        HOLDOFF
    } state_t;

    state_t      state;
    logic [15:0] pend_cct;
    logic        pend;
    logic        force_pend;
    logic        committed;
    logic [15:0] launch_cct;
    logic [7:0]  timer;
    logic [23:0] hold_cnt;
    logic [15:0] cct_delta;

    always_comb begin
        if (pend_cct >= last_cct) cct_delta = pend_cct - last_cct;
        else                      cct_delta = last_cct - pend_cct;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pend_cct     <= 16'd0;
            pend         <= 1'b0;
            force_pend   <= 1'b0;
            committed    <= 1'b0;
            launch_cct   <= 16'd0;
            timer        <= 8'd0;
            hold_cnt     <= 24'd0;
            conv_cct     <= 16'd0;
            conv_start   <= 1'b0;
            busy         <= 1'b0;
            update_done  <= 1'b0;
            last_cct     <= DEFAULT_CCT;
            update_count <= 16'd0;
            timeout_err  <= 1'b0;
        end else begin
            conv_start  <= 1'b0;
            update_done <= 1'b0;
            if (err_clr) timeout_err <= 1'b0;

            // Capture runs in every state so nothing is lost while busy or holding off.
            if (als_valid) begin
                pend_cct <= als_cct;
                pend     <= 1'b1;
            end
            if (force_update) force_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (enable) state <= WAIT_SAMPLE;
                end
                WAIT_SAMPLE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (force_pend) begin
                        launch_cct <= pend ? pend_cct : last_cct;
                        busy       <= 1'b1;
                        state      <= LAUNCH;
                    end else if (pend && (!committed || cct_delta >= HYST)) begin
                        launch_cct <= pend_cct;
                        busy       <= 1'b1;
                        state      <= LAUNCH;
                    end else if (pend && !als_valid) begin
                        pend <= 1'b0;
                    end
                end
                LAUNCH: begin
                    conv_start <= 1'b1;
                    conv_cct   <= launch_cct;
                    if (!force_update) force_pend <= 1'b0;
                    if (!als_valid) pend <= 1'b0;
                    timer <= 8'd0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A result arriving on the timeout cycle still commits.
                    if (conv_done) begin
                        last_cct     <= conv_cct;
                        update_count <= update_count + 16'd1;
                        update_done  <= 1'b1;
                        committed    <= 1'b1;
                        busy         <= 1'b0;
                        hold_cnt     <= 24'd0;
                        state        <= HOLDOFF;
                    end else if (timer == TIMEOUT - 8'd1) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        hold_cnt    <= 24'd0;
                        state       <= HOLDOFF;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt == MIN_INTERVAL - 24'd1) begin
                        state <= enable ? WAIT_SAMPLE : IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 24'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cct_update_scheduler.sv
// Scoreboard bench for cct_update_scheduler: the driver predicts launches and commits from
// the hysteresis/force rules, and a negedge monitor checks every conv_start and update_done.
module tb_cct_update_scheduler;
    localparam logic [15:0] HYST = 16'd50;
    localparam int          MI   = 8;
    localparam int          TO   = 16;
    localparam logic [15:0] DEF  = 16'd6500;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] als_cct;
    logic        als_valid;
    logic        force_update;
    logic        err_clr;
    logic [15:0] conv_cct;
    logic        conv_start;
    logic        conv_done;
    logic        busy;
    logic        update_done;
    logic [15:0] last_cct;
    logic [15:0] update_count;
    logic        timeout_err;

    cct_update_scheduler #(
        .HYST(HYST),
        .MIN_INTERVAL(24'(MI)),
        .TIMEOUT(8'(TO)),
        .DEFAULT_CCT(DEF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .als_cct(als_cct),
        .als_valid(als_valid),
        .force_update(force_update),
        .err_clr(err_clr),
        .conv_cct(conv_cct),
        .conv_start(conv_start),
        .conv_done(conv_done),
        .busy(busy),
        .update_done(update_done),
        .last_cct(last_cct),
        .update_count(update_count),
        .timeout_err(timeout_err)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Scoreboard state and behavioural model
    typedef struct packed {
        logic [15:0] cct;
        logic [15:0] count;
    } commit_t;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    commit_t     commit_q[$];
    logic [15:0] m_last;
    logic        m_committed;
    logic [15:0] m_count;
    logic        m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch rule: force always launches (pending sample or last committed value);
    // otherwise a sample launches if nothing is committed yet or it moved by >= HYST.
    task automatic predict(input logic has, input logic [15:0] v, input logic f,
                           output logic go, output logic [15:0] val);
        int d;
        d = int'(v) - int'(m_last);
        if (d < 0) d = -d;
        go  = 1'b0;
        val = 16'd0;
        if (f) begin
            go  = 1'b1;
            val = has ? v : m_last;
        end else if (has && (!m_committed || d >= int'(HYST))) begin
            go  = 1'b1;
            val = v;
        end
    endtask

    // Monitor
    logic [15:0] mon_cct;
    commit_t     mon_c;
    always @(negedge clk) begin
        if (rst_n) begin
            if (conv_start) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_conv_start", 32'(conv_start), 0);
                end else begin
                    mon_cct = exp_q.pop_front();
                    check("conv_cct", 32'(conv_cct), 32'(mon_cct));
                end
            end
            if (update_done) begin
                if (commit_q.size() == 0) begin
                    check("unexpected_update_done", 32'(update_done), 0);
                end else begin
                    mon_c = commit_q.pop_front();
                    check("last_cct", 32'(last_cct), 32'(mon_c.cct));
                    check("update_count", 32'(update_count), 32'(mon_c.count));
                end
            end
        end
    end

    // Driver tasks
    task automatic send(input logic has, input logic [15:0] v, input logic f);
        als_cct      = v;
        als_valid    = has;
        force_update = f;
        tick();
        als_valid    = 1'b0;
        force_update = 1'b0;
    endtask

    task automatic wait_launch(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (conv_start) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("conv_start_seen", 32'(conv_start), 1);
    endtask

    // Called in the conv_start cycle; resp = cycles until conv_done, 0 = never answer.
    task automatic finish_txn(input logic [15:0] val, input int resp, input logic clr);
        check("busy_in_wait_done", 32'(busy), 1);
        if (resp > 0) begin
            repeat (resp) tick();
            commit_q.push_back(commit_t'{cct: val, count: m_count + 16'd1});
            conv_done = 1'b1;
            tick();
            conv_done = 1'b0;
            check("update_done_seen", 32'(update_done), 1);
            check("busy_after_commit", 32'(busy), 0);
            m_last      = val;
            m_count     = m_count + 16'd1;
            m_committed = 1'b1;
        end else begin
            repeat (TO - 1) tick();
            check("timeout_err_early", 32'(timeout_err), 0);
            err_clr = clr;
            tick();
            err_clr = 1'b0;
            check("timeout_err_set", 32'(timeout_err), 1);
            check("last_cct_after_timeout", 32'(last_cct), 32'(m_last));
            check("count_after_timeout", 32'(update_count), 32'(m_count));
            m_err = 1'b1;
        end
    endtask

    task automatic step(input logic has, input logic [15:0] v, input logic f,
                        input int resp, input logic clr, input logic hold);
        logic        go;
        logic [15:0] val;
        int          lat;
        check("timeout_err_state", 32'(timeout_err), 32'(m_err));
        if (resp == 0 && m_err) begin
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            check("err_clr", 32'(timeout_err), 0);
            m_err = 1'b0;
        end
        predict(has, v, f, go, val);
        if (go) exp_q.push_back(val);
        send(has, v, f);
        if (go) begin
            wait_launch(4, lat);
            check("launch_latency", 32'(lat), 2);
            if (lat > 0) finish_txn(val, resp, clr);
            if (hold) repeat (MI + 2) tick();
        end else begin
            repeat (4) tick();
        end
    endtask

    task automatic check_reset_values();
        check("rst_conv_start", 32'(conv_start), 0);
        check("rst_update_done", 32'(update_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_conv_cct", 32'(conv_cct), 0);
        check("rst_update_count", 32'(update_count), 0);
        check("rst_last_cct", 32'(last_cct), 32'(DEF));
    endtask

    // Stimulus
    initial begin
        logic        go;
        logic [15:0] val;
        int          lat;
        int          tmp;
        logic        f;
        logic        has;
        int          resp;

        rst_n = 1'b0; enable = 1'b0; als_cct = 16'd0; als_valid = 1'b0;
        force_update = 1'b0; err_clr = 1'b0; conv_done = 1'b0;
        m_last = DEF; m_committed = 1'b0; m_count = 16'd0; m_err = 1'b0;
        repeat (3) tick();
        check_reset_values();
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) tick();

        // Basic commit, hysteresis reject, pend cleared, force with no sample
        step(1'b1, 16'd3000, 1'b0, 4, 1'b0, 1'b1);
        step(1'b1, 16'd3040, 1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 16'd0,    1'b1, 2, 1'b0, 1'b1);
        step(1'b1, 16'd3050, 1'b0, 2, 1'b0, 1'b0);

        // Samples during hold-off: only the latest is launched
        predict(1'b1, 16'd7000, 1'b0, go, val);
        if (go) exp_q.push_back(val);
        send(1'b1, 16'd4000, 1'b0);
        send(1'b1, 16'd5000, 1'b0);
        send(1'b1, 16'd7000, 1'b0);
        wait_launch(MI + 10, lat);
        if (lat > 0) finish_txn(16'd7000, 3, 1'b0);
        repeat (MI + 2) tick();

        // Timeouts, err_clr, and err_clr coinciding with a new timeout
        step(1'b1, 16'd5000, 1'b0, 0, 1'b0, 1'b1);
        step(1'b1, 16'd3000, 1'b0, 0, 1'b1, 1'b1);
        step(1'b1, 16'd5000, 1'b0, 1, 1'b0, 1'b1);
        step(1'b0, 16'd0,    1'b1, 2, 1'b0, 1'b1);

        // Hysteresis boundary on both sides
        step(1'b1, 16'd5049, 1'b0, 3, 1'b0, 1'b1);
        step(1'b1, 16'd5050, 1'b0, 3, 1'b0, 1'b1);
        step(1'b1, 16'd5001, 1'b0, 5, 1'b0, 1'b1);
        step(1'b1, 16'd5000, 1'b0, TO - 1, 1'b0, 1'b1);

        // enable dropped mid-transaction: commit still happens, then the scheduler parks
        predict(1'b1, 16'd6000, 1'b0, go, val);
        if (go) exp_q.push_back(val);
        send(1'b1, 16'd6000, 1'b0);
        wait_launch(4, lat);
        enable = 1'b0;
        if (lat > 0) finish_txn(16'd6000, 3, 1'b0);
        repeat (MI + 2) tick();
        check("busy_parked", 32'(busy), 0);
        send(1'b1, 16'd6500, 1'b0);
        repeat (5) tick();
        predict(1'b1, 16'd6500, 1'b0, go, val);
        if (go) exp_q.push_back(val);
        enable = 1'b1;
        wait_launch(8, lat);
        if (lat > 0) finish_txn(16'd6500, 1, 1'b0);
        repeat (MI + 2) tick();

        // Randomised traffic
        for (int it = 0; it < 40; it++) begin
            f    = ($urandom_range(0, 9) < 2);
            has  = f ? 1'($urandom_range(0, 1)) : 1'b1;
            tmp  = int'(m_last) + int'($urandom_range(0, 200)) - 100;
            resp = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO - 1));
            step(has, 16'(tmp), f, resp, 1'($urandom_range(0, 1)), 1'b1);
        end

        // Reset in WAIT_DONE abandons the transaction; a late conv_done is ignored
        check("timeout_err_pre_reset", 32'(timeout_err), 32'(m_err));
        predict(1'b1, 16'd4000, 1'b1, go, val);
        if (go) exp_q.push_back(val);
        send(1'b1, 16'd4000, 1'b1);
        wait_launch(4, lat);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        check_reset_values();
        rst_n = 1'b1;
        m_last = DEF; m_committed = 1'b0; m_count = 16'd0; m_err = 1'b0;
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        repeat (4) tick();
        check("late_done_count", 32'(update_count), 0);
        check("late_done_last", 32'(last_cct), 32'(DEF));
        step(1'b1, 16'd6510, 1'b0, 2, 1'b0, 1'b1);

        check("exp_q_drained", 32'(exp_q.size()), 0);
        check("commit_q_drained", 32'(commit_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cct_update_scheduler.md
# cct_update_scheduler

Sequencing controller in front of the CCT-to-XYZ converter. Accepts the raw ALS colour-temperature stream and launches a conversion only when the reading has moved by at least a hysteresis threshold, or when software forces one. Enforces a minimum hold-off between conversions, tracks each conversion to completion with a timeout, and reports the last committed CCT to the downstream adaptation-matrix logic.

## Interface
Parameters:
- HYST, 16'd50: minimum |new − last committed| CCT, in Kelvin, that triggers a conversion.
- MIN_INTERVAL, 24'd1000: hold-off cycles after each transaction; must be ≥ 1.
- TIMEOUT, 8'd16: cycles to wait for conv_done; must be ≥ 2.
- DEFAULT_CCT, 16'd6500: last_cct value after reset.

Ports:
- clk, in, 1: single clock; all logic on its rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- enable, in, 1: scheduler enable.
- als_cct, in, 16: raw CCT in Kelvin.
- als_valid, in, 1: als_cct is valid this cycle.
- force_update, in, 1: single-cycle request to convert regardless of hysteresis.
- err_clr, in, 1: clears timeout_err.
- conv_cct, out, 16: CCT presented to the converter; held stable from conv_start until the transaction ends.
- conv_start, out, 1: one-cycle launch pulse (drives the converter's cct_valid).
- conv_done, in, 1: converter result valid (xyz_valid).
- busy, out, 1: high in LAUNCH and WAIT_DONE.
- update_done, out, 1: one-cycle pulse when a conversion commits.
- last_cct, out, 16: last committed CCT.
- update_count, out, 16: committed conversions; wraps modulo 2^16.
- timeout_err, out, 1: sticky; set on timeout.

## Operation
- FSM states: IDLE, WAIT_SAMPLE, LAUNCH, WAIT_DONE, HOLDOFF. Reset state is IDLE.
- Sample capture runs in every state:
  - als_valid loads pend_cct and sets pend.
  - The latest sample wins.
  - force_update sets force_pend.
- IDLE:
  - If enable is high, go to WAIT_SAMPLE.
  - Otherwise hold; pend and force_pend are kept.
- WAIT_SAMPLE:
  - If enable is low, go to IDLE.
  - Else if force_pend: go to LAUNCH with launch value = pend_cct if pend is set, else last_cct.
  - Else if pend and |pend_cct − last_cct| ≥ HYST (16-bit unsigned absolute difference): go to LAUNCH with launch value pend_cct.
  - Else if pend (difference below HYST): clear pend and stay.
  - "First conversion since reset" always launches. A committed flag, cleared at reset, bypasses hysteresis.
- LAUNCH:
  - conv_start = 1 and conv_cct = launch value.
  - Clear force_pend.
  - Clear pend, unless als_valid is high this same cycle; in that case the new sample is retained.
  - Load the timeout timer with 0 and go to WAIT_DONE.
- WAIT_DONE:
  - On conv_done: last_cct ← conv_cct, update_count++, update_done pulse, set committed, go to HOLDOFF.
  - Else, if the timer reaches TIMEOUT−1: set timeout_err, leave last_cct and update_count unchanged, go to HOLDOFF.
  - Else increment the timer.
  - conv_done wins if it coincides with the timeout cycle.
- HOLDOFF:
  - Count MIN_INTERVAL cycles, then go to WAIT_SAMPLE if enable is high, else IDLE.
  - Samples and force requests received here are queued, not dropped.
- enable low during LAUNCH or WAIT_DONE does not abort the transaction. It takes effect at the exit of HOLDOFF.
- conv_done outside WAIT_DONE is ignored.
- err_clr clears timeout_err. If a set event coincides with err_clr, set wins.
- No clamping is performed here; range clamping belongs to the converter.

## Timing
- Reset values (rst_n sampled low at a clock edge):
  - conv_start, update_done, busy, timeout_err: 0.
  - conv_cct: 0; update_count: 0; last_cct: DEFAULT_CCT.
  - pend, force_pend, committed: 0; state IDLE.
- Reset asserted mid-transaction abandons it. A late conv_done after reset is ignored (state IDLE).
- All outputs are registered.
- Latency from an als_valid cycle (state WAIT_SAMPLE, pend clear) to conv_start: 2 cycles.
  - Edge N captures the sample.
  - Edge N+1 makes the decision.
  - conv_start is high after edge N+2 for exactly one cycle.
- Commit timing: update_done and the last_cct update become visible one cycle after the conv_done cycle.
- Minimum spacing between conv_start pulses: MIN_INTERVAL + 4 cycles, with a 1-cycle converter response.
- Timeout: timeout_err rises TIMEOUT cycles after the conv_start cycle.

## Test plan
- Reset, enable=1, als_cct=3000 pulse → conv_start 2 cycles later with conv_cct=3000; conv_done returned after 4 cycles → last_cct=3000, update_count=1, update_done single pulse.
- After commit at 3000 with HYST=50: sample 3040 → no conv_start, pend cleared; sample 3050 → conv_start with conv_cct=3050.
- During HOLDOFF, send samples 4000, 5000, 7000 → exactly one conv_start after hold-off, with conv_cct=7000.
- conv_done never returned → timeout_err=1 at conv_start+16; last_cct and update_count unchanged. err_clr → 0. err_clr concurrent with a new timeout → 1.
- force_update with no pending sample and last_cct=5000 → conv_start with conv_cct=5000 despite zero delta; update_count increments.
- enable dropped in WAIT_DONE → transaction completes and commits, HOLDOFF runs, then state is IDLE. rst_n low during WAIT_DONE → all outputs at reset values, and a later conv_done has no effect.
